// File: rtl/regfile_param_if.sv
// Register-file access bundle: one write port, two read ports,
// pending scoreboard control and hazard/ready status.
interface regfile_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              pend_set;
    logic [ADDR_W-1:0] pend_addr;
    logic              haz1;
    logic              haz2;
    logic              ready;

    modport master (
        output we, wa, wd,
        output ra1, ra2,
        output pend_set, pend_addr,
        input  rd1, rd2,
        input  haz1, haz2,
        input  ready
    );

    modport slave (
        input  we, wa, wd,
        input  ra1, ra2,
        input  pend_set, pend_addr,
        output rd1, rd2,
        output haz1, haz2,
        output ready
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: init sweep after reset, optional
// write-to-read bypass, optional zero register, pending scoreboard.
module regfile_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input logic           clk,
    input logic           rst,
    regfile_param_if.slave rf_if
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZA   = '0;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [DATA_W-1:0] rf_q [DEPTH];

    logic              run;
    logic              wr_ok;
    logic              ps_ok;
    logic              st_we;
    logic [ADDR_W-1:0] st_wa;
    logic [DATA_W-1:0] st_wd;

    assign run   = (state_q == S_RUN);
    assign wr_ok = run && rf_if.we
                 && !(ZR && rf_if.wa == ZA);
    assign ps_ok = run && rf_if.pend_set
                 && !(ZR && rf_if.pend_addr == ZA);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        unique case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_RUN;
                    ready_d = 1'b1;
                end
            end
            S_RUN: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_INIT;
                ready_d = 1'b0;
            end
        endcase
    end

    // Issuing a new producer wins over a retiring write to the same reg.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok) pend_d[rf_if.wa] = 1'b0;
        if (ps_ok) pend_d[rf_if.pend_addr] = 1'b1;
    end

    always_comb begin
        st_we = 1'b0;
        st_wa = cnt_q;
        st_wd = '0;
        unique case (1'b1)
            !run: begin
                st_we = 1'b1;
            end
            wr_ok: begin
                st_we = 1'b1;
                st_wa = rf_if.wa;
                st_wd = rf_if.wd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            pend_q  <= pend_d;
        end
    end

    // Storage has no reset; the sweep clears it after rst drops.
    always_ff @(posedge clk) begin
        if (!rst && st_we) rf_q[st_wa] <= st_wd;
    end

    logic              z1, z2;
    logic              byp1, byp2;
    logic [DATA_W-1:0] rd1, rd2;
    logic              haz1, haz2;

    assign z1   = ZR && (rf_if.ra1 == ZA);
    assign z2   = ZR && (rf_if.ra2 == ZA);
    assign byp1 = BP && wr_ok && (rf_if.wa == rf_if.ra1);
    assign byp2 = BP && wr_ok && (rf_if.wa == rf_if.ra2);

    always_comb begin
        rd1  = rf_q[rf_if.ra1];
        haz1 = pend_q[rf_if.ra1];
        priority case (1'b1)
            !run: begin
                rd1  = '0;
                haz1 = 1'b0;
            end
            z1: begin
                rd1  = '0;
                haz1 = 1'b0;
            end
            byp1: begin
                rd1  = rf_if.wd;
                haz1 = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd2  = rf_q[rf_if.ra2];
        haz2 = pend_q[rf_if.ra2];
        priority case (1'b1)
            !run: begin
                rd2  = '0;
                haz2 = 1'b0;
            end
            z2: begin
                rd2  = '0;
                haz2 = 1'b0;
            end
            byp2: begin
                rd2  = rf_if.wd;
                haz2 = 1'b0;
            end
            default: ;
        endcase
    end

    assign rf_if.rd1   = rd1;
    assign rf_if.rd2   = rd2;
    assign rf_if.haz1  = haz1;
    assign rf_if.haz2  = haz2;
    assign rf_if.ready = ready_q;
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two configurations driven in lockstep
// and compared against an array-based reference model.
module tb_regfile_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        we = 1'b0;
    logic [2:0]  wa = '0;
    logic [15:0] wd = '0;
    logic [2:0]  ra1 = '0;
    logic [2:0]  ra2 = '0;
    logic        ps = 1'b0;
    logic [2:0]  pa = '0;

    regfile_param_if #(.DATA_W(16), .ADDR_W(3)) ifa ();
    regfile_param_if #(.DATA_W(16), .ADDR_W(3)) ifb ();

    assign ifa.we = we;
    assign ifa.wa = wa;
    assign ifa.wd = wd;
    assign ifa.ra1 = ra1;
    assign ifa.ra2 = ra2;
    assign ifa.pend_set = ps;
    assign ifa.pend_addr = pa;
    assign ifb.we = we;
    assign ifb.wa = wa;
    assign ifb.wd = wd;
    assign ifb.ra1 = ra1;
    assign ifb.ra2 = ra2;
    assign ifb.pend_set = ps;
    assign ifb.pend_addr = pa;

    regfile_param #(
        .DATA_W(16), .ADDR_W(3),
        .ZERO_REG(0), .BYPASS(1)
    ) dut_a (
        .clk(clk), .rst(rst), .rf_if(ifa)
    );

    regfile_param #(
        .DATA_W(16), .ADDR_W(3),
        .ZERO_REG(1), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rst(rst), .rf_if(ifb)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model; index 0 = dut_a, 1 = dut_b.
    logic [15:0] m_rf [2][8];
    bit          m_pend [2][8];
    int          m_left = 8;
    bit          m_valid = 1'b0;

    function automatic bit zr(input int i);
        return i == 1;
    endfunction

    function automatic bit bp(input int i);
        return i == 0;
    endfunction

    function automatic bit wr_lands(input int i);
        return m_left == 0 && we && !(zr(i) && wa == 0);
    endfunction

    function automatic logic [31:0] e_rd(input int i,
                                         input logic [2:0] ra);
        if (m_left != 0) return 0;
        if (zr(i) && ra == 0) return 0;
        if (bp(i) && wr_lands(i) && wa == ra) return 32'(wd);
        return 32'(m_rf[i][ra]);
    endfunction

    function automatic logic [31:0] e_haz(input int i,
                                          input logic [2:0] ra);
        if (m_left != 0) return 0;
        if (zr(i) && ra == 0) return 0;
        if (bp(i) && wr_lands(i) && wa == ra) return 0;
        return 32'(m_pend[i][ra]);
    endfunction

    task automatic drive(input bit r, input bit w,
                         input logic [2:0] a,
                         input logic [15:0] d,
                         input logic [2:0] x1,
                         input logic [2:0] x2,
                         input bit p,
                         input logic [2:0] q);
        @(negedge clk);
        rst = r; we = w; wa = a; wd = d;
        ra1 = x1; ra2 = x2; ps = p; pa = q;
        #1;
        if (m_valid) begin
            chk("a_ready", 32'(ifa.ready), 32'(m_left == 0));
            chk("a_rd1", 32'(ifa.rd1), e_rd(0, ra1));
            chk("a_rd2", 32'(ifa.rd2), e_rd(0, ra2));
            chk("a_haz1", 32'(ifa.haz1), e_haz(0, ra1));
            chk("a_haz2", 32'(ifa.haz2), e_haz(0, ra2));
            chk("b_ready", 32'(ifb.ready), 32'(m_left == 0));
            chk("b_rd1", 32'(ifb.rd1), e_rd(1, ra1));
            chk("b_rd2", 32'(ifb.rd2), e_rd(1, ra2));
            chk("b_haz1", 32'(ifb.haz1), e_haz(1, ra1));
            chk("b_haz2", 32'(ifb.haz2), e_haz(1, ra2));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_left = 8;
            m_valid = 1'b1;
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < 8; k++)
                    m_pend[i][k] = 1'b0;
        end else if (m_left != 0) begin
            for (int i = 0; i < 2; i++)
                m_rf[i][8 - m_left] = '0;
            m_left--;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_lands(i)) begin
                    m_rf[i][wa] = wd;
                    m_pend[i][wa] = 1'b0;
                end
                if (ps && !(zr(i) && pa == 0))
                    m_pend[i][pa] = 1'b1;
            end
        end
    endtask

    task automatic idle(input logic [2:0] x1,
                        input logic [2:0] x2);
        drive(0, 0, 0, 0, x1, x2, 0, 0);
    endtask

    initial begin
        // Reset sweep with writes attempted during INIT
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int c = 0; c < 8; c++) begin
            drive(0, 1, 3, 16'hBEEF, 3, 3, 1, 3);
            chk("tp1_init_rdy", 32'(ifa.ready), 0);
            tick();
        end
        idle(3, 3);
        chk("tp1_run_rdy", 32'(ifa.ready), 1);
        chk("tp1_rd", 32'(ifa.rd1), 0);
        chk("tp1_haz", 32'(ifa.haz1), 0);
        tick();

        // Write then read
        drive(0, 1, 5, 16'h1234, 0, 0, 0, 0);
        tick();
        idle(5, 5);
        chk("tp2_a1", 32'(ifa.rd1), 32'h1234);
        chk("tp2_a2", 32'(ifa.rd2), 32'h1234);
        chk("tp2_b1", 32'(ifb.rd1), 32'h1234);
        tick();

        // Bypass vs no bypass
        drive(0, 1, 2, 16'h00AA, 0, 0, 0, 0);
        tick();
        drive(0, 1, 2, 16'h5555, 2, 0, 0, 0);
        chk("tp3_byp", 32'(ifa.rd1), 32'h5555);
        chk("tp3_nobyp", 32'(ifb.rd1), 32'h00AA);
        tick();

        // Zero register
        drive(0, 1, 0, 16'hFFFF, 0, 0, 1, 0);
        tick();
        idle(0, 0);
        chk("tp4_zr_rd", 32'(ifb.rd1), 0);
        chk("tp4_zr_haz", 32'(ifb.haz1), 0);
        chk("tp4_nz_rd", 32'(ifa.rd1), 32'hFFFF);
        chk("tp4_nz_haz", 32'(ifa.haz1), 1);
        tick();

        // Scoreboard
        drive(0, 0, 0, 0, 0, 0, 1, 4);
        tick();
        idle(0, 4);
        chk("tp5_set", 32'(ifa.haz2), 1);
        tick();
        drive(0, 1, 4, 16'h4444, 0, 0, 1, 4);
        tick();
        idle(0, 4);
        chk("tp5_both", 32'(ifa.haz2), 1);
        chk("tp5_both_d", 32'(ifa.rd2), 32'h4444);
        tick();
        drive(0, 1, 4, 16'h4545, 0, 4, 0, 0);
        chk("tp5_byp_haz", 32'(ifa.haz2), 0);
        chk("tp5_nobyp_haz", 32'(ifb.haz2), 1);
        tick();
        idle(0, 4);
        chk("tp5_clr_a", 32'(ifa.haz2), 0);
        chk("tp5_clr_b", 32'(ifb.haz2), 0);
        tick();

        // Reset mid-operation
        drive(0, 1, 6, 16'h0F0F, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 6, 6, 1, 6);
        tick();
        idle(6, 6);
        chk("tp6_pre_haz", 32'(ifa.haz1), 1);
        chk("tp6_pre_rd", 32'(ifa.rd1), 32'h0F0F);
        tick();
        drive(1, 0, 0, 0, 6, 6, 0, 0);
        tick();
        for (int c = 0; c < 8; c++) begin
            idle(6, 6);
            chk("tp6_rdy", 32'(ifa.ready), 0);
            chk("tp6_haz", 32'(ifa.haz1), 0);
            tick();
        end
        idle(6, 6);
        chk("tp6_rdy1", 32'(ifa.ready), 1);
        chk("tp6_rd", 32'(ifa.rd1), 0);
        tick();

        // Random traffic with occasional resets
        for (int c = 0; c < 800; c++) begin
            drive(($urandom_range(0, 99) == 0),
                  1'($urandom),
                  3'($urandom), 16'($urandom),
                  3'($urandom), 3'($urandom),
                  ($urandom_range(0, 2) == 0),
                  3'($urandom));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
